// File: rtl/spm_serial_mult.sv
// spm_serial_mult -- parametrised serial-parallel multiplier.
//
// A WIDTH-bit multiplicand x is held in parallel. The multiplier y is shifted
// in LSB-first through a carry-save chain with one cell per x bit. The
// 2*WIDTH-bit product appears serially on p_bit, LSB first, and is also
// collected into a parallel product register.
//
// Ports:
//   clk         rising-edge clock for all state
//   rst         synchronous, active-low reset
//   start       request a multiply; taken only while ready=1
//   signed_mode 1 = two's-complement operands, 0 = unsigned (sampled with start)
//   x           parallel multiplicand (sampled with start)
//   y           multiplier (sampled with start, then consumed LSB-first)
//   ready       block can accept start (IDLE or DONE)
//   p_valid     p_bit carries a product bit this cycle
//   p_bit       serial product bit, LSB first
//   done        one-cycle pulse when the product is complete
//   product     full product, held from done until the next accepted start

// One carry-save cell: a plain full adder. The carry stays in the cell's own
// flop and the sum moves one cell towards the LSB each cycle.
module spm_csa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);
endmodule

module spm_serial_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(2*WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               ready,
  output logic               p_valid,
  output logic               p_bit,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Last serial step: cycle T0+2*WIDTH carries product bit 2*WIDTH-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2*WIDTH-1);

  logic [1:0]         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_sr_q;
  logic               smode_q;
  logic [WIDTH-1:1]   sum_q;     // sum of cell i, consumed by cell i-1
  logic [WIDTH-1:0]   carry_q;   // carry of cell i, consumed by cell i
  logic [2*WIDTH-1:0] product_q;

  logic               running;
  logic               ybit;
  logic [WIDTH-1:0]   cell_a;
  logic [WIDTH-1:0]   cell_b;
  logic [WIDTH-1:0]   cell_s;
  logic [WIDTH-1:0]   cell_co;

  assign running = (state_q == ST_RUN);
  assign ybit    = y_sr_q[0];

  // Partial-product bits for this cycle's multiplier bit.
  assign cell_a = x_q & {WIDTH{ybit}};

  // Sum input of every cell comes from the cell above. For the MSB cell in
  // signed mode, the infinite run of sign-extended columns above it all hold
  // the same state as the MSB cell itself (same sign-extended addend bit,
  // same sum, same carry), so the column feeding it is folded onto its own
  // registered sum. Unsigned mode has nothing above the MSB cell.
  assign cell_b = {smode_q & sum_q[WIDTH-1], sum_q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    spm_csa_cell u_cell (
      .a   (cell_a[i]),
      .b   (cell_b[i]),
      .cin (carry_q[i]),
      .s   (cell_s[i]),
      .co  (cell_co[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      x_q       <= '0;
      y_sr_q    <= '0;
      smode_q   <= 1'b0;
      sum_q     <= '0;
      carry_q   <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_RUN;
            x_q       <= x;
            y_sr_q    <= y;
            smode_q   <= signed_mode;
            sum_q     <= '0;
            carry_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
          end else begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
          end
        end

        ST_RUN: begin
          sum_q   <= cell_s[WIDTH-1:1];
          carry_q <= cell_co;
          // Arithmetic shift in signed mode keeps feeding y[WIDTH-1] once the
          // original bits are used up; unsigned mode feeds zeros.
          y_sr_q  <= {smode_q & y_sr_q[WIDTH-1], y_sr_q[WIDTH-1:1]};

          for (int unsigned k = 0; k < 2*WIDTH; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              product_q[k] <= cell_s[0];
            end
          end

          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ready   = !running;
  assign p_valid = running;
  assign p_bit   = running & cell_s[0];
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_spm_serial_mult.sv
// Self-checking bench for spm_serial_mult at WIDTH=8.
// Expected products are queued when a start is driven and popped when the
// DUT raises done; serial and parallel results are compared against them.
module tb_spm_serial_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   x = '0;
  logic [W-1:0]   y = '0;
  logic           ready;
  logic           p_valid;
  logic           p_bit;
  logic           done;
  logic [2*W-1:0] product;

  int vectors = 0;
  int miscompares = 0;
  logic [2*W-1:0] exp_q[$];

  spm_serial_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .x           (x),
    .y           (y),
    .ready       (ready),
    .p_valid     (p_valid),
    .p_bit       (p_bit),
    .done        (done),
    .product     (product)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    longint pa, pb, r;
    if (sm) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'({56'd0, a});
      pb = longint'({56'd0, b});
    end
    r = pa * pb;
    return r[2*W-1:0];
  endfunction

  // Drives start for the current cycle (T0) and queues the expected product.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sm, input logic [2*W-1:0] e);
    x = a;
    y = b;
    signed_mode = sm;
    start = 1'b1;
    exp_q.push_back(e);
  endtask

  // Follows one run from T0+1 to done. Optionally pulses a foreign start at
  // cycle T0+inject_at, and optionally chains the next start in the done cycle.
  task automatic collect(input string name, input int inject_at, input bit chain,
                         input logic [W-1:0] na, input logic [W-1:0] nb,
                         input logic nsm, input logic [2*W-1:0] ne);
    logic [2*W-1:0] ser;
    logic [2*W-1:0] e;
    int nv;
    bit got;
    ser = '0;
    nv = 0;
    got = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      step();
      start = 1'b0;
      if (n == 1) begin
        vectors++;
        if (product !== '0) begin
          miscompares++;
          $display("FAIL %s product_clear: got %h want %h", name, product, 16'h0000);
        end
      end
      vectors++;
      if (p_valid !== (n <= 2*W)) begin
        miscompares++;
        $display("FAIL %s p_valid@T0+%0d: got %b want %b", name, n, p_valid, (n <= 2*W));
      end
      if (p_valid === 1'b1) begin
        vectors++;
        if (ready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s ready_busy@T0+%0d: got %b want 0", name, n, ready);
        end
        if (nv < 2*W) ser[nv] = p_bit;
        nv++;
      end
      if (n == inject_at) begin
        start = 1'b1;
        x = ~x;
        y = y ^ 8'h5A;
        signed_mode = ~signed_mode;
      end
      if (done === 1'b1) begin
        got = 1'b1;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s scoreboard_empty: got done with product %h, want no done", name, product);
        end else begin
          e = exp_q.pop_front();
          vectors += 4;
          if (n != 2*W+1) begin
            miscompares++;
            $display("FAIL %s done_latency: got T0+%0d want T0+%0d", name, n, 2*W+1);
          end
          if (nv != 2*W) begin
            miscompares++;
            $display("FAIL %s valid_count: got %0d want %0d", name, nv, 2*W);
          end
          if (ser !== e) begin
            miscompares++;
            $display("FAIL %s serial: got %h want %h", name, ser, e);
          end
          if (product !== e) begin
            miscompares++;
            $display("FAIL %s parallel: got %h want %h", name, product, e);
          end
          if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_done: got %b want 1", name, ready);
          end
        end
        if (chain) drive_start(na, nb, nsm, ne);
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s done_timeout: got no done in 40 cycles, want done at T0+%0d", name, 2*W+1);
    end
  endtask

  // Cycle after done without a new start: back in IDLE, product held.
  task automatic post_idle(input string name, input logic [2*W-1:0] e);
    step();
    vectors++;
    if (done !== 1'b0 || ready !== 1'b1 || p_valid !== 1'b0 || product !== e) begin
      miscompares++;
      $display("FAIL %s idle_hold: got done=%b ready=%b p_valid=%b product=%h want 0 1 0 %h",
               name, done, ready, p_valid, product, e);
    end
  endtask

  task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input logic [2*W-1:0] e);
    drive_start(a, b, sm, e);
    collect(name, 0, 1'b0, '0, '0, 1'b0, '0);
    post_idle(name, e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    vectors++;
    if (ready !== 1'b1 || p_valid !== 1'b0 || p_bit !== 1'b0 || done !== 1'b0 || product !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got ready=%b p_valid=%b p_bit=%b done=%b product=%h want 1 0 0 0 0000",
               ready, p_valid, p_bit, done, product);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_unsigned();
    run_one("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run_one("u_80_7f", 8'h80, 8'h7F, 1'b0, 16'h3F80);
    run_one("u_zero",  8'h00, 8'hA5, 1'b0, 16'h0000);
  endtask

  task automatic test_signed();
    run_one("s_80_7f", 8'h80, 8'h7F, 1'b1, 16'hC080);
    run_one("s_ff_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
    run_one("s_zero",  8'h00, 8'hA5, 1'b1, 16'h0000);
    run_one("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic sm;
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      sm = 1'($urandom_range(0, 1));
      run_one("rand", a, b, sm, model(a, b, sm));
    end
  endtask

  task automatic test_back_to_back();
    drive_start(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    collect("b2b_first", 0, 1'b1, 8'd3, 8'd5, 1'b0, 16'h000F);
    collect("b2b_second", 0, 1'b0, '0, '0, 1'b0, '0);
    post_idle("b2b_second", 16'h000F);
  endtask

  task automatic test_start_ignored();
    drive_start(8'h5A, 8'hC3, 1'b1, model(8'h5A, 8'hC3, 1'b1));
    collect("start_ignored", 5, 1'b0, '0, '0, 1'b0, '0);
    post_idle("start_ignored", model(8'h5A, 8'hC3, 1'b1));
  endtask

  task automatic test_abort();
    bit saw_done;
    drive_start(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    for (int n = 1; n <= 6; n++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b0;
    step();
    vectors++;
    if (ready !== 1'b1 || p_valid !== 1'b0 || done !== 1'b0 || product !== '0) begin
      miscompares++;
      $display("FAIL abort_reset: got ready=%b p_valid=%b done=%b product=%h want 1 0 0 0000",
               ready, p_valid, done, product);
    end
    rst = 1'b1;
    exp_q.delete();
    saw_done = 1'b0;
    for (int n = 0; n < 24; n++) begin
      step();
      if (done === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL abort_no_done: got done pulse want none");
    end
    run_one("after_abort", 8'd2, 8'd7, 1'b0, 16'h000E);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at 500000, want finished");
    $fatal(1);
  end

endmodule
